// File: rtl/systolic_array_feeder.sv
// rtl/systolic_array_feeder.sv - skewing source driver for an m x n systolic matmul array
// Runs clear -> stream -> drain per job and skews A/B beats into the array's row/col inputs.
module systolic_array_feeder #(
  parameter int m           = 16,
  parameter int n           = 16,
  parameter int input_width = 8,
  parameter int k_max       = 256,
  parameter int pe_latency  = 1,
  localparam int KW         = $clog2(k_max + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [KW-1:0]              k_len,
  output logic                       busy,
  output logic                       done,
  input  logic                       beat_valid,
  output logic                       beat_ready,
  input  logic [m*input_width-1:0]   beat_a,
  input  logic [n*input_width-1:0]   beat_b,
  output logic                       array_clr,
  output logic [m*input_width-1:0]   in_row,
  output logic [n*input_width-1:0]   in_col
);

  localparam int D  = m + n - 1 + pe_latency;
  localparam int DW = $clog2(D + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [KW-1:0]   r_k_len;
  logic [KW-1:0]   r_beat_cnt;
  logic [DW-1:0]   r_drain_cnt;
  logic            w_accept;

  assign beat_ready = (r_state == S_STREAM) && (r_beat_cnt != r_k_len);
  assign w_accept   = beat_valid && beat_ready;
  assign busy       = (r_state == S_CLEAR) || (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign array_clr  = (r_state == S_CLEAR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CLEAR;
      S_CLEAR:  w_next = (r_k_len == '0) ? S_DRAIN : S_STREAM;
      S_STREAM: if (w_accept && ((r_beat_cnt + KW'(1)) == r_k_len)) w_next = S_DRAIN;
      S_DRAIN:  if (r_drain_cnt == DW'(D - 1)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_k_len <= k_len;
      if (r_state == S_CLEAR)  r_beat_cnt <= '0;
      else if (w_accept)       r_beat_cnt <= r_beat_cnt + 1'b1;
      if (r_state == S_DRAIN)  r_drain_cnt <= r_drain_cnt + 1'b1;
      else                     r_drain_cnt <= '0;
    end
  end

  // Non-accepted cycles feed zeros so stalls become zero-product slots in the array.
  genvar gi;
  for (gi = 0; gi < m; gi++) begin : g_row
    logic [input_width-1:0] w_in;
    logic [input_width-1:0] r_out;
    assign w_in = w_accept ? beat_a[gi*input_width +: input_width] : '0;
    assign in_row[gi*input_width +: input_width] = r_out;
    if (gi == 0) begin : g_nodly
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_out <= '0;
        else        r_out <= w_in;
      end
    end else begin : g_dly
      logic [input_width-1:0] r_line [gi];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < gi; s++) r_line[s] <= '0;
          r_out <= '0;
        end else begin
          r_line[0] <= w_in;
          for (int s = 1; s < gi; s++) r_line[s] <= r_line[s-1];
          r_out <= r_line[gi-1];
        end
      end
    end
  end

  genvar gj;
  for (gj = 0; gj < n; gj++) begin : g_col
    logic [input_width-1:0] w_in;
    logic [input_width-1:0] r_out;
    assign w_in = w_accept ? beat_b[gj*input_width +: input_width] : '0;
    assign in_col[gj*input_width +: input_width] = r_out;
    if (gj == 0) begin : g_nodly
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_out <= '0;
        else        r_out <= w_in;
      end
    end else begin : g_dly
      logic [input_width-1:0] r_line [gj];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < gj; s++) r_line[s] <= '0;
          r_out <= '0;
        end else begin
          r_line[0] <= w_in;
          for (int s = 1; s < gj; s++) r_line[s] <= r_line[s-1];
          r_out <= r_line[gj-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_feeder.sv
// tb/tb_systolic_array_feeder.sv - scoreboard bench for systolic_array_feeder
// Lane timing and C = A*B (via an ideal array model fed by the DUT streams) checked per job.
module tb_systolic_array_feeder;

  localparam int M    = 2;
  localparam int N    = 2;
  localparam int W    = 8;
  localparam int KMAX = 8;
  localparam int PEL  = 1;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int D    = M + N - 1 + PEL;
  localparam int AW   = M * W;
  localparam int BW   = N * W;
  localparam int MAXC = 4000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_a;
  logic [BW-1:0] beat_b;
  logic          array_clr;
  logic [AW-1:0] in_row;
  logic [BW-1:0] in_col;

  systolic_array_feeder #(
    .m(M), .n(N), .input_width(W), .k_max(KMAX), .pe_latency(PEL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_a(beat_a), .beat_b(beat_b), .array_clr(array_clr),
    .in_row(in_row), .in_col(in_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  bit [W-1:0] exp_row  [MAXC][M];
  bit [W-1:0] exp_col  [MAXC][N];
  bit [W-1:0] hist_row [MAXC][M];
  bit [W-1:0] hist_col [MAXC][N];
  bit [W-1:0] mat_a    [KMAX][M];
  bit [W-1:0] mat_b    [KMAX][N];
  int         done_q[$];
  longint     c_q[$];
  int         start_cyc = 0;
  int         job_k = 0;
  int         acc = 0;
  int         clr_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: actual %0d expected %0d at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: lane scoreboard plus an ideal array where PE(i,j) sees row i delayed j, col j delayed i.
  always @(negedge clk) begin
    longint s;
    for (int i = 0; i < M; i++) begin
      chk($sformatf("in_row lane %0d", i), in_row[i*W +: W], exp_row[cyc][i]);
      hist_row[cyc][i] = in_row[i*W +: W];
    end
    for (int j = 0; j < N; j++) begin
      chk($sformatf("in_col lane %0d", j), in_col[j*W +: W], exp_col[cyc][j]);
      hist_col[cyc][j] = in_col[j*W +: W];
    end
    if (reset) begin
      if (!busy && !done && start) begin
        start_cyc = cyc;
        job_k = int'(k_len);
        acc = 0;
        if (k_len == 0) done_q.push_back(cyc + 2 + D);
      end
      if (array_clr) begin
        clr_cyc = cyc;
        chk("array_clr cycle", cyc, start_cyc + 1);
      end
      if (beat_ready) chk("beat_ready implies busy", busy, 1);
      if (beat_valid && beat_ready) begin
        for (int i = 0; i < M; i++) exp_row[cyc + 1 + i][i] = beat_a[i*W +: W];
        for (int j = 0; j < N; j++) exp_col[cyc + 1 + j][j] = beat_b[j*W +: W];
        acc++;
        if (acc == job_k) done_q.push_back(cyc + D + 1);
      end
      if (done) begin
        chk("pending jobs at done", done_q.size(), 1);
        if (done_q.size() > 0) begin
          chk("done cycle", cyc, done_q.pop_front());
          chk("beats per job", acc, job_k);
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
              s = 0;
              for (int c = clr_cyc + 1; c <= cyc - PEL; c++)
                s += longint'(hist_row[c - j][i]) * longint'(hist_col[c - i][j]);
              if (c_q.size() > 0) chk($sformatf("C[%0d][%0d]", i, j), s, c_q.pop_front());
            end
        end
      end
    end
  end

  task automatic run_job(input int k, input int mode, input int gap, input bit spam);
    int bound;
    int idx;
    int g;
    int s_cyc;
    longint cexp;
    bound = 0;
    @(posedge clk); #1;
    while ((busy || done) && bound < 200) begin
      @(posedge clk); #1;
      bound++;
    end
    chk("idle before job", busy | done, 0);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        cexp = 0;
        for (int t = 0; t < k; t++) cexp += longint'(mat_a[t][i]) * longint'(mat_b[t][j]);
        c_q.push_back(cexp);
      end
    start = 1'b1;
    k_len = KW'(k);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    g = 0;
    bound = 0;
    while (idx < k && bound < 300) begin
      if (g > 0) begin
        beat_valid = 1'b0;
        beat_a = AW'($urandom);
        beat_b = BW'($urandom);
        g--;
      end else begin
        beat_valid = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
        for (int i = 0; i < M; i++) beat_a[i*W +: W] = mat_a[idx][i];
        for (int j = 0; j < N; j++) beat_b[j*W +: W] = mat_b[idx][j];
      end
      if (spam) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (beat_valid && beat_ready) begin
        idx++;
        g = (mode == 1) ? gap : 0;
      end
      @(posedge clk); #1;
      bound++;
    end
    chk("beats delivered", idx, k);
    bound = 0;
    while (!done && bound < 300) begin
      beat_valid = 1'($urandom_range(0, 1));
      beat_a = AW'($urandom);
      beat_b = BW'($urandom);
      if (spam) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bound++;
    end
    start = 1'b0;
    beat_valid = 1'b0;
    chk("done seen", done, 1);
    if (mode != 2)
      chk("start-to-done latency", cyc - s_cyc, k + 2 + D + ((mode == 1 && k > 0) ? gap * (k - 1) : 0));
  endtask

  task automatic load_test1();
    mat_a[0][0] = 1; mat_a[0][1] = 3; mat_a[1][0] = 2; mat_a[1][1] = 4;
    mat_b[0][0] = 5; mat_b[0][1] = 6; mat_b[1][0] = 7; mat_b[1][1] = 8;
  endtask

  task automatic load_random();
    for (int t = 0; t < KMAX; t++) begin
      for (int i = 0; i < M; i++) mat_a[t][i] = W'($urandom);
      for (int j = 0; j < N; j++) mat_b[t][j] = W'($urandom);
    end
  endtask

  initial begin
    int bound;
    reset = 1'b0;
    start = 1'b0;
    k_len = '0;
    beat_valid = 1'b0;
    beat_a = '0;
    beat_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset beat_ready", beat_ready, 0);
    chk("reset array_clr", array_clr, 0);
    chk("reset in_row", in_row, 0);
    chk("reset in_col", in_col, 0);
    reset = 1'b1;

    load_test1();
    run_job(2, 0, 0, 1'b0);

    mat_a[0][0] = 8'h11; mat_a[0][1] = 8'h22;
    mat_b[0][0] = 8'h33; mat_b[0][1] = 8'h44;
    run_job(1, 0, 0, 1'b0);

    load_test1();
    run_job(2, 1, 3, 1'b0);

    run_job(0, 0, 0, 1'b0);

    // Abort a job after its first beat; the next job must see no stale data.
    load_random();
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    bound = 0;
    while (acc < 1 && bound < 50) begin
      beat_valid = 1'b1;
      for (int i = 0; i < M; i++) beat_a[i*W +: W] = mat_a[acc][i];
      for (int j = 0; j < N; j++) beat_b[j*W +: W] = mat_b[acc][j];
      @(posedge clk); #1;
      bound++;
    end
    chk("abort job first beat", acc, 1);
    #2;
    reset = 1'b0;
    for (int c = cyc; c < MAXC; c++) begin
      for (int i = 0; i < M; i++) exp_row[c][i] = '0;
      for (int j = 0; j < N; j++) exp_col[c][j] = '0;
    end
    done_q.delete();
    c_q.delete();
    #1;
    chk("mid-reset in_row", in_row, 0);
    chk("mid-reset in_col", in_col, 0);
    chk("mid-reset busy", busy, 0);
    chk("mid-reset beat_ready", beat_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    beat_valid = 1'b0;
    reset = 1'b1;
    load_test1();
    run_job(2, 0, 0, 1'b0);

    load_random();
    run_job(3, 0, 0, 1'b1);

    load_random();
    run_job(KMAX, 2, 0, 1'b0);

    repeat (12) begin
      load_random();
      run_job($urandom_range(0, KMAX), $urandom_range(0, 2), $urandom_range(1, 3),
              1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("leftover done expectations", done_q.size(), 0);
    chk("leftover C expectations", c_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
